// File: rtl/sc_arb.sv
// sc_arb: round-robin arbiter for four requesters sharing a 3-bit saturating
// event counter. The owner increments the counter with inc, releases with
// rel[owner], or is forcibly released by a hold watchdog. Protocol
// violations raise a one-cycle err pulse.
module sc_arb #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] rel,
  input  logic       inc,
  input  logic       ctr_rst,
  output logic [3:0] gnt,
  output logic [2:0] out,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    OWN  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  state_t     state_r;
  logic [1:0] ptr_r;
  logic [7:0] hold_r;
  logic [3:0] gnt_r;
  logic [2:0] out_r;
  logic       busy_r;
  logic       err_r;

  logic [1:0] cand_s;
  logic [1:0] win_idx_s;
  logic       win_found_s;
  logic       in_own_s;
  logic       owner_rel_s;
  logic       rel_err_s;
  logic       inc_err_s;
  logic       inc_ok_s;
  logic       sat_err_s;
  logic       wd_s;
  logic       viol_s;

  assign gnt  = gnt_r;
  assign out  = out_r;
  assign busy = busy_r;
  assign err  = err_r;

  // Round-robin winner search over req, starting at ptr_r and wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = ptr_r;
    cand_s      = ptr_r;
    for (int i = 0; i < 4; i++) begin
      cand_s = ptr_r + 2'(i);
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Decode release, increment acceptance, watchdog expiry and violations.
  always_comb begin
    in_own_s    = (state_r == OWN);
    owner_rel_s = in_own_s & (|(rel & gnt_r));
    if (in_own_s) begin
      rel_err_s = |(rel & ~gnt_r);
    end else begin
      rel_err_s = |rel;
    end
    inc_err_s = inc & ~in_own_s;
    inc_ok_s  = in_own_s & inc & (out_r != 3'd7);
    // A clear in the same cycle overrides the saturating increment.
    sat_err_s = in_own_s & inc & ~ctr_rst & (out_r == 3'd7);
    wd_s      = in_own_s & (hold_r == HOLD_LIM);
    viol_s    = inc_err_s | rel_err_s | sat_err_s | wd_s;
  end

  // Ownership FSM: state, grant, pointer, hold watchdog, busy and err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 2'd0;
      hold_r  <= 8'd0;
      gnt_r   <= 4'b0000;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      err_r <= viol_s;
      case (state_r)
        IDLE: begin
          if (|req) begin
            state_r <= ARB;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        ARB: begin
          if (win_found_s) begin
            state_r <= OWN;
            gnt_r   <= 4'b0001 << win_idx_s;
            ptr_r   <= win_idx_s + 2'd1;
            hold_r  <= 8'd0;
          end else begin
            // All requests withdrawn: back to IDLE quietly.
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        OWN: begin
          if (owner_rel_s || wd_s) begin
            state_r <= IDLE;
            gnt_r   <= 4'b0000;
            busy_r  <= 1'b0;
            hold_r  <= 8'd0;
          end else if (inc_ok_s) begin
            hold_r <= 8'd0;
          end else begin
            hold_r <= hold_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt_r   <= 4'b0000;
          busy_r  <= 1'b0;
          hold_r  <= 8'd0;
        end
      endcase
    end
  end

  // Saturating counter: clear has priority, grant clears, owner increments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r <= 3'd0;
    end else if (ctr_rst) begin
      out_r <= 3'd0;
    end else if ((state_r == ARB) && win_found_s) begin
      out_r <= 3'd0;
    end else if (inc_ok_s) begin
      out_r <= out_r + 3'd1;
    end else begin
      out_r <= out_r;
    end
  end

endmodule

// File: doc/sc_arb.md
# sc_arb

Round-robin arbiter and controller for a shared 3-bit saturating event counter. Up to four requesters compete for ownership. The single owner increments the counter through a pulse interface, and ownership is released explicitly or by a hold watchdog. The block sits between the requesting agents and the counter resource: it sequences counter clears on every ownership change and reports protocol violations on `err`.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive owner cycles with no `inc` before forced release; range 1–255.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 4: per-requester ownership request, level.
- `rel` in 4: per-requester release strobe, one cycle.
- `inc` in 1: increment strobe from the current owner.
- `ctr_rst` in 1: synchronous counter clear; ownership is unaffected.
- `gnt` out 4: one-hot grant, registered; all zero when no owner.
- `out` out 3: counter value, registered.
- `busy` out 1: high in states ARB and OWN.
- `err` out 1: one-cycle registered violation pulse.

## Operation
- **States:** IDLE, ARB, OWN. Reset state is IDLE.
- **IDLE:**
  - If any `req` bit is high, go to ARB.
  - Otherwise stay in IDLE.
- **ARB:**
  - Pick the winner from `req`, sampled in this cycle, by round-robin search starting at index `ptr`.
  - Set the winner's `gnt` bit, clear `out` to 0, and go to OWN.
  - If `req` is all zero in ARB (withdrawn), return to IDLE with no grant and no error.
- **Round-robin pointer:**
  - `ptr` resets to 0.
  - On each grant, `ptr` becomes winner+1 mod 4.
- **OWN:**
  - The owner keeps the grant while it holds `req`; dropping its `req` bit does not release.
  - Release happens only on `rel[owner]` or the watchdog.
  - On release: `gnt` goes to 0 and the state goes to IDLE next cycle; `out` holds its final value until the next ARB clears it.
- **Counter:**
  - `inc` in OWN with `out` < 7: `out` becomes `out`+1.
  - `inc` in OWN with `out` == 7: `out` stays at 7 and `err` pulses.
  - `ctr_rst` in any state: `out` becomes 0. It takes priority over `inc` and over the ARB clear (same result).
- **Watchdog:**
  - A hold counter of width 8 clears on grant and on every accepted `inc`, and increments on other OWN cycles.
  - When it reaches `HOLD_MAX`: forced release (as `rel`) and `err` pulses.
- **`err` sources** (OR-ed, one pulse per offending cycle):
  - `inc` outside OWN;
  - any `rel` bit from a non-owner, or while not in OWN;
  - `inc` at saturation;
  - watchdog expiry.
- **Simultaneous events:**
  - `inc` and `rel[owner]` in the same cycle: the increment is applied, then release.
  - `rel[owner]` and watchdog expiry in the same cycle: release with `err` from the watchdog.
  - `rel` and `req` from the same owner: the release wins; that requester re-arbitrates from IDLE at the lowest priority.
- **Reset mid-operation:** immediate return to IDLE.

## Timing
- **Reset values:** `gnt`=0000, `out`=000, `busy`=0, `err`=0, `ptr`=0, hold counter = 0.
- **Grant latency:** `req` high in IDLE at cycle t gives `gnt` at t+2 (t+1 is ARB), with `out` = 0 at t+2.
- **Release latency:** `rel` at cycle t gives `gnt`=0 at t+1. The earliest new grant is t+3.
- **Counter latency:** `inc` or `ctr_rst` at t is visible on `out` at t+1.
- **`err` latency:** `err` is asserted in cycle t+1 for a violation in cycle t.
- **Watchdog:** with no `inc`, the forced release is seen as `gnt`=0 exactly `HOLD_MAX`+1 cycles after the first `gnt` cycle.
- **`busy` timing:** `busy` rises with ARB and falls in the same cycle `gnt` falls.

## Test plan
- **Reset during ownership:**
  - Stimulus: assert `rst` while `gnt`=0010 and `out`=5.
  - Response: all outputs 0 asynchronously; after deassert, `req`=0001 gives `gnt`=0001 (`ptr`=0).
- **Round-robin:**
  - Stimulus: `req`=1111 held, owner releases after 1 `inc` each time.
  - Response: grant order 0001, 0010, 0100, 1000, 0001; `out`=1 at each release; 2-cycle gap between grants.
- **Saturation:**
  - Stimulus: 9 consecutive `inc` pulses while owning.
  - Response: `out` goes 1..7 then stays at 7; `err` pulses on the cycles after the 8th and 9th `inc`.
- **`ctr_rst` vs `inc`:**
  - Stimulus: `out`=3, `ctr_rst` and `inc` asserted together.
  - Response: `out`=0 next cycle, no `err`, grant unchanged.
- **Watchdog (`HOLD_MAX`=4):**
  - Stimulus: grant with no `inc`.
  - Response: `gnt` falls after 5 grant cycles; `err` pulses once.
  - Follow-up: an `inc` at hold count 3 delays the release by 4 cycles.
- **Protocol errors:**
  - Stimulus: `rel`=0100 while requester 0 owns; `inc` in IDLE.
  - Response: one `err` pulse each; requester 0 keeps `gnt`; `out` is unchanged by the IDLE `inc`.
